// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between two native
// valid/ready requesters (m0 = CPU, m1 = second bus master).
// Every access takes the same IDLE -> ACCESS -> RESP path.
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate between m0 and m1. When undefined, m0 always wins.
module mem_arbiter #(
  parameter int MEM_SIZE = 4096,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;

  // Fields latched at grant time, so requester changes after grant are ignored
  logic grant;
  logic acc_oor;
  logic acc_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_grant;
`endif

  logic        m0_elig;
  logic        m1_elig;
  logic        pick_m1;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_oor;
  logic [31:0] resp_data;
  logic        unused_addr_bits;

  // A requester that is completing this cycle still shows valid, so mask it
  assign m0_elig = m0_valid & ~m0_ready;
  assign m1_elig = m1_valid & ~m1_ready;

  // Arbitration choice, grant-side request mux and range check
  always_comb begin
    pick_m1   = 1'b0;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_wstrb = m0_wstrb;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    pick_m1 = m1_elig & (~m0_elig | ~last_grant);
`else
    pick_m1 = m1_elig & ~m0_elig;
`endif
    if (pick_m1) begin
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_wstrb = m1_wstrb;
    end
    sel_oor = ({2'b00, sel_addr[31:2]} >= 32'(MEM_SIZE));
  end

  // Reads return RAM data; writes and out-of-range accesses return zero
  assign resp_data = (acc_oor | acc_write) ? 32'h0 : ram_rdata;

  // Byte offset within a word has no meaning for a word-wide RAM
  assign unused_addr_bits = ^sel_addr[1:0];

  // Access sequencer: grant in IDLE, RAM strobe in ACCESS, ready pulse in RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      acc_oor   <= 1'b0;
      acc_write <= 1'b0;
      m0_ready  <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_ready  <= 1'b0;
      m1_rdata  <= 32'h0;
      ram_en    <= 1'b0;
      ram_we    <= 4'h0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      err       <= 1'b0;
      busy      <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          m0_rdata <= 32'h0;
          m1_rdata <= 32'h0;
          err      <= 1'b0;
          if (m0_elig | m1_elig) begin
            grant     <= pick_m1;
            acc_oor   <= sel_oor;
            acc_write <= |sel_wstrb;
            ram_en    <= ~sel_oor;
            ram_we    <= sel_oor ? 4'h0 : sel_wstrb;
            ram_addr  <= sel_addr[ADDR_W+1:2];
            ram_wdata <= sel_wdata;
            busy      <= 1'b1;
            state     <= ACCESS;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant <= pick_m1;
`endif
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= 4'h0;
          state  <= RESP;
        end
        RESP: begin
          if (grant) begin
            m1_ready <= 1'b1;
            m1_rdata <= resp_data;
          end else begin
            m0_ready <= 1'b1;
            m0_rdata <= resp_data;
          end
          err   <= acc_oor;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
